// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central stall/flush controller for the 5-stage pipeline. Each cycle it
//   decides, combinationally from registered state and current inputs, which
//   pipeline registers hold, which take a bubble, and whether the MEM_WB write
//   is suppressed. Three sources, highest priority first:
//     1. multi-cycle memory/MMIO access in MEM (req/ready with timeout)
//     2. taken branch/jump resolved in EX
//     3. load-use hazard between EX (load) and ID
//   Saturating stall/flush counters and a sticky timeout flag feed debug MMIO.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   id_rs1/id_rs2, id_use_rs1/2   ID-stage source registers and their use bits
//   ex_mem_read, ex_rd            EX-stage load flag and destination register
//   ex_branch_taken               EX resolved a taken branch this cycle
//   mem_req, mem_ready            MEM-stage access request / completion
//   *_stall                       hold the named pipeline register
//   if_id_flush, id_ex_flush      load a bubble into the named register
//   wb_bubble                     suppress the register write on MEM_WB input
//   err_timeout                   sticky: a memory access timed out
//   stall_cnt, flush_cnt          saturating cycle counts of pc_stall/id_ex_flush

// Saturating up-counter used for the performance counters.
module phc_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
  end
endmodule

module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 255   // legal range 2..65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_mem_stall,
  output logic        mem_wb_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        wb_bubble,
  output logic        err_timeout,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_nxt;
  logic        err_set;
  logic        load_use;

  // A load in EX whose destination is read by the ID instruction. x0 never
  // carries a real dependency.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (err_set) err_timeout <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and Mealy hazard outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    wait_nxt     = wait_cnt;
    err_set      = 1'b0;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    wb_bubble    = 1'b0;

    if (!rst) begin
      // Memory hold: freeze everything up to EX_MEM and let MEM_WB take a
      // bubble each cycle; MEM_WB itself keeps advancing so the instruction
      // ahead of the access retires. Branch/load-use are ignored here since
      // their instructions are held and re-evaluated on release.
      if ((state == RUN && mem_req && !mem_ready) ||
          (state == MEM_WAIT && !mem_ready && wait_cnt < TMO)) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        wb_bubble    = 1'b1;
        state_nxt    = MEM_WAIT;
        wait_nxt     = (state == RUN) ? 16'd1 : wait_cnt + 16'd1;
      end else begin
        if (state == MEM_WAIT) begin
          // Release: ready arrived, or the timeout forced it. A timed-out
          // result is garbage, so its write-back is still suppressed.
          state_nxt = RUN;
          wait_nxt  = '0;
          if (!mem_ready) begin
            wb_bubble = 1'b1;
            err_set   = 1'b1;
          end
        end
        // The branch squashes the dependent ID instruction anyway, so it
        // overrides the load-use stall.
        if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  phc_sat_cnt #(.W(16)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (pc_stall),
    .cnt (stall_cnt)
  );

  phc_sat_cnt #(.W(16)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (id_ex_flush),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (TIMEOUT = 4).
// Inputs change 1 ns after each posedge; combinational outputs are sampled
// 1 ns later, registered state right after the following posedge.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
  logic        mem_req, mem_ready;
  logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic        if_id_flush, id_ex_flush, wb_bubble, err_timeout;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  // Output vector: {pc, if_id, id_ex, ex_mem, mem_wb stalls, if_id_flush, id_ex_flush, wb_bubble}
  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_LU   = 8'b1100_0010;
  localparam logic [7:0] O_BR   = 8'b0000_0110;
  localparam logic [7:0] O_MEM  = 8'b1111_0001;
  localparam logic [7:0] O_TMO  = 8'b0000_0001;

  logic [7:0] outs;
  assign outs = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
                 if_id_flush, id_ex_flush, wb_bubble};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .id_ex_stall     (id_ex_stall),
    .ex_mem_stall    (ex_mem_stall),
    .mem_wb_stall    (mem_wb_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .wb_bubble       (wb_bubble),
    .err_timeout     (err_timeout),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    ex_mem_read = 1'b1; ex_rd = rd; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    // Reset forces outputs low even with hazards present.
    set_lu(5'd5); mem_req = 1'b1;
    #1;
    chk("rst_outs", 32'(outs), 32'(O_NONE));
    tick(); tick();
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);

    // ---- load-use on rs2 ----
    rst = 1'b0; idle(); set_lu(5'd5);
    #1 chk("lu_outs", 32'(outs), 32'(O_LU));
    tick();
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("lu_flush_cnt", 32'(flush_cnt), 32'd1);
    idle();
    #1 chk("lu_after", 32'(outs), 32'(O_NONE));
    tick();
    // ex_rd = 0 never hazards
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    #1 chk("lu_x0", 32'(outs), 32'(O_NONE));
    tick();
    // rs1 match, then rs1 match without use bit
    idle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    #1 chk("lu_rs1", 32'(outs), 32'(O_LU));
    tick();
    id_use_rs1 = 1'b0;
    #1 chk("lu_rs1_unused", 32'(outs), 32'(O_NONE));
    tick();
    chk("lu_cnt2_stall", 32'(stall_cnt), 32'd2);

    // ---- branch beats load-use ----
    idle(); set_lu(5'd5); ex_branch_taken = 1'b1;
    #1 chk("br_vs_lu", 32'(outs), 32'(O_BR));
    tick();
    chk("br_stall_cnt", 32'(stall_cnt), 32'd2);
    chk("br_flush_cnt", 32'(flush_cnt), 32'd3);

    // ---- memory wait, ready on 4th cycle ----
    idle(); mem_req = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1 chk($sformatf("mw_stall%0d", i), 32'(outs), 32'(O_MEM));
      tick();
    end
    mem_ready = 1'b1;
    #1 chk("mw_release", 32'(outs), 32'(O_NONE));
    tick();
    idle();
    #1 chk("mw_back_run", 32'(outs), 32'(O_NONE));
    tick();
    chk("mw_stall_cnt", 32'(stall_cnt), 32'd5);
    mem_req = 1'b1; mem_ready = 1'b1;
    #1 chk("mw_1cycle", 32'(outs), 32'(O_NONE));
    tick();
    idle();
    #1 chk("mw_1cycle_run", 32'(outs), 32'(O_NONE));
    tick();

    // ---- branch held during a 2-cycle wait ----
    mem_req = 1'b1; ex_branch_taken = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      #1 chk($sformatf("bw_stall%0d", i), 32'(outs), 32'(O_MEM));
      tick();
    end
    mem_ready = 1'b1;
    #1 chk("bw_release", 32'(outs), 32'(O_BR));
    tick();
    chk("bw_stall_cnt", 32'(stall_cnt), 32'd7);
    chk("bw_flush_cnt", 32'(flush_cnt), 32'd4);

    // ---- timeout (TIMEOUT = 4) ----
    idle(); mem_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1 chk($sformatf("to_stall%0d", i), 32'(outs), 32'(O_MEM));
      tick();
    end
    chk("to_err_before", 32'(err_timeout), 32'd0);
    #1 chk("to_release", 32'(outs), 32'(O_TMO));
    tick();
    chk("to_err", 32'(err_timeout), 32'd1);
    idle();
    #1 chk("to_run", 32'(outs), 32'(O_NONE));
    tick();
    chk("to_err_sticky", 32'(err_timeout), 32'd1);
    chk("to_stall_cnt", 32'(stall_cnt), 32'd11);

    // ---- reset in the middle of MEM_WAIT ----
    mem_req = 1'b1;
    tick(); tick();
    rst = 1'b1;
    #1 chk("rmw_outs_in_rst", 32'(outs), 32'(O_NONE));
    tick();
    rst = 1'b0; idle();
    #1 chk("rmw_run", 32'(outs), 32'(O_NONE));
    chk("rmw_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rmw_flush_cnt", 32'(flush_cnt), 32'd0);
    chk("rmw_err", 32'(err_timeout), 32'd0);
    tick();

    // ---- saturation: 70000 cycles of load-use ----
    set_lu(5'd5);
    repeat (65534) @(posedge clk);
    #1 chk("sat_stall_m1", 32'(stall_cnt), 32'hFFFE);
    tick();
    chk("sat_stall_max", 32'(stall_cnt), 32'hFFFF);
    repeat (4465) @(posedge clk);
    #1;
    chk("sat_stall_hold", 32'(stall_cnt), 32'hFFFF);
    chk("sat_flush_hold", 32'(flush_cnt), 32'hFFFF);
    chk("sat_outs", 32'(outs), 32'(O_LU));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
